sata_8b10b_enc: RTL and testbench

Clocked, multi-lane 8b/10b encoder for the SATA transmit path with running-disparity tracking carried across lanes and across words. It accepts NLANES control/data characters per beat through a valid/ready stream, encodes them in lane order, and presents registered 10-bit symbols to the serializer. It is the synthesizable, pipelined successor to the combinational single-character encoder model and must be bit-exact with it for every valid input.

---
 rtl/sata_8b10b_pkg.sv | 46 ++++
 rtl/sata_8b10b_lane.sv | 40 ++++
 rtl/sata_8b10b_enc.sv | 75 +++++++
 tb/tb_sata_8b10b_enc.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sata_8b10b_pkg.sv
// Shared 8b/10b code tables and selection helpers for the SATA encoder.
// Tables hold the RD- variant of each sub-block; the RD+ variant is derived
// by inversion, except for balanced codes, which are sent unchanged.
package sata_8b10b_pkg;

   // 5b/6b codes (abcdei, a = MSB), RD- variant, indexed by EDCBA
   localparam logic [5:0] CODE6_RDM [32] = '{
      6'b100111, 6'b011101, 6'b101101, 6'b110001,
      6'b110101, 6'b101001, 6'b011001, 6'b111000,
      6'b111001, 6'b100101, 6'b010101, 6'b110100,
      6'b001101, 6'b101100, 6'b011100, 6'b010111,
      6'b011011, 6'b100011, 6'b010011, 6'b110010,
      6'b001011, 6'b101010, 6'b011010, 6'b111010,
      6'b110011, 6'b100110, 6'b010110, 6'b110110,
      6'b001110, 6'b101110, 6'b011110, 6'b101011
   };

   // 3b/4b codes (fghj, f = MSB), RD- variant, indexed by HGF (x.7 is P7)
   localparam logic [3:0] CODE4_RDM [8] = '{
      4'b1011, 4'b1001, 4'b0101, 4'b1100,
      4'b1101, 4'b1010, 4'b0110, 4'b1110
   };

   localparam logic [5:0] K28_6B_RDM = 6'b001111;
   // D.7 is balanced but still has distinct RD- / RD+ forms
   localparam logic [5:0] D7_6B_RDM  = 6'b111000;
   // fghj form of the alternate x.7 code (A7) at RD-
   localparam logic [3:0] A7_4B_RDM  = 4'b0111;
   // D.x.3 is balanced but still has distinct RD- / RD+ forms
   localparam logic [3:0] DX3_4B_RDM = 4'b1100;

   // Control codes that the encoder is allowed to emit
   function automatic logic is_legal_k(input logic [7:0] b);
      return (b[4:0] == 5'd28) || (b == 8'hF7) || (b == 8'hFB) ||
             (b == 8'hFD) || (b == 8'hFE);
   endfunction

   // Data x.7 needs A7 to avoid a run of five equal bits across e/i/f/g/h
   function automatic logic use_a7(input logic [4:0] x, input logic rd);
      if (rd)
         return (x == 5'd11) || (x == 5'd13) || (x == 5'd14);
      else
         return (x == 5'd17) || (x == 5'd18) || (x == 5'd20);
   endfunction

endpackage

// File: rtl/sata_8b10b_lane.sv
// Combinational single-character 8b/10b encoder with RD in/out so lanes chain.
module sata_8b10b_lane
   import sata_8b10b_pkg::*;
(
   input  logic       rd_in,
   input  logic [8:0] din,
   output logic [9:0] code,
   output logic       rd_out,
   output logic       kerr
);

   logic [4:0] x;
   logic [2:0] y;
   logic       k_bad, k_ok, k28, bal6, rd6, a7, neut4;
   logic [5:0] c6_rdm, c6;
   logic [3:0] c4_base, c4_rdm, c4;

   // 6b sub-block from rd_in, then 4b sub-block from the 6b ending RD
   always_comb begin
      x       = din[4:0];
      y       = din[7:5];
      k_bad   = din[8] && !is_legal_k(din[7:0]);
      k_ok    = din[8] && !k_bad;
      k28     = k_ok && (x == 5'd28);
      c6_rdm  = k28 ? K28_6B_RDM : CODE6_RDM[x];
      bal6    = ($countones(c6_rdm) == 3);
      c6      = (rd_in && !(bal6 && (c6_rdm != D7_6B_RDM))) ? ~c6_rdm : c6_rdm;
      rd6     = bal6 ? rd_in : !rd_in;
      a7      = (y == 3'd7) && (k_ok || use_a7(x, rd6));
      c4_base = a7 ? A7_4B_RDM : CODE4_RDM[y];
      neut4   = ($countones(c4_base) == 2) && (c4_base != DX3_4B_RDM);
      // control characters flip even the balanced 4b codes with RD
      c4_rdm  = (k_ok && neut4) ? ~c4_base : c4_base;
      c4      = (rd6 && (k_ok || !neut4)) ? ~c4_rdm : c4_rdm;
      rd_out  = ($countones(c4_base) == 2) ? rd6 : !rd6;
      code    = {c6, c4};
      kerr    = k_bad;
   end

endmodule

// File: rtl/sata_8b10b_enc.sv
// Multi-lane 8b/10b encoder: valid/ready handshake, output register and the
// running-disparity register; lanes are chained so RD flows lane 0 -> N-1.
module sata_8b10b_enc
   import sata_8b10b_pkg::*;
#(
   parameter int NLANES       = 4,
   parameter bit OPT_LOWPOWER = 1'b0
) (
   input  logic                  i_clk,
   input  logic                  i_reset_n,
   input  logic                  i_rd_clear,
   input  logic                  S_VALID,
   output logic                  S_READY,
   input  logic [9*NLANES-1:0]   S_DATA,
   output logic                  M_VALID,
   input  logic                  M_READY,
   output logic [10*NLANES-1:0]  M_DATA,
   output logic [NLANES-1:0]     o_kerr,
   output logic                  o_rd
);

   logic [10*NLANES-1:0] code_p0, data_p1;
   logic [NLANES-1:0]    kerr_p0, kerr_p1;
   logic [NLANES:0]      rd_chain;
   logic                 vld_p1, rd_p1, clr_pend, accept;

   assign S_READY     = !vld_p1 || M_READY;
   assign accept      = S_VALID && S_READY;
   // a clear seen without an accept is remembered until the next beat, so
   // the reported RD of a held beat never changes
   assign rd_chain[0] = (i_rd_clear || clr_pend) ? 1'b0 : rd_p1;

   for (genvar n = 0; n < NLANES; n++) begin : g_lane
      sata_8b10b_lane u_lane (
         .rd_in  (rd_chain[n]),
         .din    (S_DATA[9*n +: 9]),
         .code   (code_p0[10*n +: 10]),
         .rd_out (rd_chain[n+1]),
         .kerr   (kerr_p0[n])
      );
   end

   // ---- stage p0 -> p1: register encoded beat, RD and handshake state ----
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         vld_p1   <= 1'b0;
         data_p1  <= '0;
         kerr_p1  <= '0;
         rd_p1    <= 1'b0;
         clr_pend <= 1'b0;
      end else if (accept) begin
         vld_p1   <= 1'b1;
         data_p1  <= code_p0;
         kerr_p1  <= kerr_p0;
         rd_p1    <= rd_chain[NLANES];
         clr_pend <= 1'b0;
      end else begin
         if (i_rd_clear)
            clr_pend <= 1'b1;
         if (M_READY) begin
            vld_p1 <= 1'b0;
            if (OPT_LOWPOWER) begin
               data_p1 <= '0;
               kerr_p1 <= '0;
            end
         end
      end
   end

   assign M_VALID = vld_p1;
   assign M_DATA  = data_p1;
   assign o_kerr  = kerr_p1;
   assign o_rd    = rd_p1;

endmodule

// File: tb/tb_sata_8b10b_enc.sv
// Directed and randomized-backpressure bench for sata_8b10b_enc (NLANES=4).
module tb_sata_8b10b_enc;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        rd_clear = 1'b0;
   logic        s_valid = 1'b0;
   logic        s_ready;
   logic [35:0] s_data = '0;
   logic        m_valid;
   logic        m_ready = 1'b1;
   logic [39:0] m_data;
   logic [3:0]  kerr;
   logic        o_rd;

   int total = 0;
   int bad   = 0;

   // IEEE 802.3 clause 36 tables, both columns written out
   localparam logic [5:0] T6M [32] = '{
      6'b100111, 6'b011101, 6'b101101, 6'b110001, 6'b110101, 6'b101001, 6'b011001, 6'b111000,
      6'b111001, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b010111,
      6'b011011, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b111010,
      6'b110011, 6'b100110, 6'b010110, 6'b110110, 6'b001110, 6'b101110, 6'b011110, 6'b101011};
   localparam logic [5:0] T6P [32] = '{
      6'b011000, 6'b100010, 6'b010010, 6'b110001, 6'b001010, 6'b101001, 6'b011001, 6'b000111,
      6'b000110, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b101000,
      6'b100100, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b000101,
      6'b001100, 6'b100110, 6'b010110, 6'b001001, 6'b001110, 6'b010001, 6'b100001, 6'b010100};
   localparam logic [3:0] T4M [8] = '{4'b1011, 4'b1001, 4'b0101, 4'b1100, 4'b1101, 4'b1010, 4'b0110, 4'b1110};
   localparam logic [3:0] T4P [8] = '{4'b0100, 4'b1001, 4'b0101, 4'b0011, 4'b0010, 4'b1010, 4'b0110, 4'b0001};
   localparam logic [3:0] K4M [8] = '{4'b1011, 4'b0110, 4'b1010, 4'b1100, 4'b1101, 4'b0101, 4'b1001, 4'b0111};
   localparam logic [3:0] K4P [8] = '{4'b0100, 4'b1001, 4'b0101, 4'b0011, 4'b0010, 4'b1010, 4'b0110, 4'b1000};
   localparam logic [7:0] KLIST [12] = '{8'h1C, 8'h3C, 8'h5C, 8'h7C, 8'h9C, 8'hBC,
                                         8'hDC, 8'hFC, 8'hF7, 8'hFB, 8'hFD, 8'hFE};

   // frequently used characters and codes
   localparam logic [8:0] D21_5 = 9'h0B5;
   localparam logic [8:0] K28_5 = 9'h1BC;
   localparam logic [9:0] C_D21_5   = 10'b1010101010;
   localparam logic [9:0] C_K285_RM = 10'b0011111010;
   localparam logic [9:0] C_K285_RP = 10'b1100000101;
   localparam logic [35:0] B1 = {K28_5, D21_5, D21_5, D21_5};
   localparam logic [35:0] B2 = {D21_5, D21_5, D21_5, K28_5};

   sata_8b10b_enc #(.NLANES(4), .OPT_LOWPOWER(1'b0)) dut (
      .i_clk      (clk),
      .i_reset_n  (rst_n),
      .i_rd_clear (rd_clear),
      .S_VALID    (s_valid),
      .S_READY    (s_ready),
      .S_DATA     (s_data),
      .M_VALID    (m_valid),
      .M_READY    (m_ready),
      .M_DATA     (m_data),
      .o_kerr     (kerr),
      .o_rd       (o_rd)
   );

   always #5 clk = ~clk;

   function automatic logic legal_k_ref(input logic [7:0] b);
      for (int i = 0; i < 12; i++)
         if (KLIST[i] == b) return 1'b1;
      return 1'b0;
   endfunction

   // reference decoder: table search that also enforces the RD column
   function automatic void decode(input logic [9:0] c, input logic rd, output logic ok,
                                  output logic [7:0] b, output logic k, output logic rd_out);
      logic [5:0] c6;
      logic [3:0] c4;
      logic       rd6, k28, f6, f4, a7, a7d;
      logic [4:0] x;
      logic [2:0] y;
      c6 = c[9:4]; c4 = c[3:0];
      ok = 1'b1; k = 1'b0; x = '0; y = '0; f6 = 1'b0; f4 = 1'b0; a7 = 1'b0;
      k28 = (c6 == (rd ? 6'b110000 : 6'b001111));
      if (k28) begin
         x = 5'd28; f6 = 1'b1;
      end else begin
         for (int i = 0; i < 32; i++)
            if ((rd ? T6P[i] : T6M[i]) == c6) begin x = i[4:0]; f6 = 1'b1; end
      end
      rd6 = ($countones(c6) == 3) ? rd : !rd;
      if (k28) begin
         k = 1'b1;
         for (int i = 0; i < 8; i++)
            if ((rd6 ? K4P[i] : K4M[i]) == c4) begin y = i[2:0]; f4 = 1'b1; end
      end else begin
         for (int i = 0; i < 8; i++)
            if ((rd6 ? T4P[i] : T4M[i]) == c4) begin y = i[2:0]; f4 = 1'b1; end
         if (c4 == (rd6 ? 4'b1000 : 4'b0111)) begin y = 3'd7; f4 = 1'b1; a7 = 1'b1; end
         a7d = rd6 ? (x == 11 || x == 13 || x == 14) : (x == 17 || x == 18 || x == 20);
         if (a7 && !a7d) begin
            if (x == 23 || x == 27 || x == 29 || x == 30) k = 1'b1;
            else ok = 1'b0;
         end
         if (!a7 && y == 3'd7 && a7d) ok = 1'b0;
      end
      ok = ok && f6 && f4;
      b = {y, x};
      rd_out = ($countones(c4) == 2) ? rd6 : !rd6;
   endfunction

   function automatic logic [35:0] rand_beat();
      logic [35:0] r;
      int          sel;
      for (int n = 0; n < 4; n++) begin
         sel = $urandom_range(0, 9);
         if (sel < 7)      r[9*n +: 9] = {1'b0, 8'($urandom_range(0, 255))};
         else if (sel < 9) r[9*n +: 9] = {1'b1, KLIST[$urandom_range(0, 11)]};
         else              r[9*n +: 9] = {1'b1, 8'($urandom_range(0, 255))};
      end
      return r;
   endfunction

   // present one beat with M_READY as set; returns at the negedge after accept
   task automatic drive_one(input logic [35:0] d, input logic clr);
      s_valid = 1'b1; s_data = d; rd_clear = clr;
      @(posedge clk); #1;
      s_valid = 1'b0; rd_clear = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset;
      rst_n = 1'b0; m_ready = 1'b1;
      #1;
      total++;
      if (m_valid !== 1'b0 || m_data !== 40'd0 || kerr !== 4'd0 || o_rd !== 1'b0) begin
         bad++;
         $display("FAIL reset_state: valid=%b data=%h kerr=%b rd=%b want 0/0/0/0", m_valid, m_data, kerr, o_rd);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      total++;
      if (s_ready !== 1'b1) begin
         bad++; $display("FAIL reset_ready: s_ready=%b want 1", s_ready);
      end
   endtask

   task automatic test_basic;
      drive_one({D21_5, D21_5, D21_5, 9'h000}, 1'b0);
      total++;
      if (m_valid !== 1'b1 || m_data !== {C_D21_5, C_D21_5, C_D21_5, 10'b1001110100}) begin
         bad++; $display("FAIL basic_data: valid=%b data=%h want 1/%h", m_valid, m_data,
                         {C_D21_5, C_D21_5, C_D21_5, 10'b1001110100});
      end
      total++;
      if (o_rd !== 1'b0 || kerr !== 4'd0) begin
         bad++; $display("FAIL basic_rd: rd=%b kerr=%b want 0/0000", o_rd, kerr);
      end
      @(posedge clk); #1;
      @(negedge clk);
      total++;
      if (m_valid !== 1'b0) begin
         bad++; $display("FAIL valid_drop: m_valid=%b want 0", m_valid);
      end
   endtask

   task automatic test_back_to_back;
      logic [39:0] exp_align;
      exp_align = {10'b0010011100, 10'b0101010101, 10'b0101010101, C_K285_RM};
      s_valid = 1'b1; s_data = {9'h07B, 9'h04A, 9'h04A, K28_5}; rd_clear = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(posedge clk); #1;
         if (i == 1) s_valid = 1'b0;
         @(negedge clk);
         total++;
         if (m_valid !== 1'b1 || m_data !== exp_align || o_rd !== 1'b0) begin
            bad++; $display("FAIL align_beat%0d: valid=%b data=%h rd=%b want 1/%h/0", i, m_valid, m_data, o_rd, exp_align);
         end
      end
   endtask

   task automatic test_rd_clear;
      drive_one(B1, 1'b1);
      total++;
      if (m_data !== {C_K285_RM, C_D21_5, C_D21_5, C_D21_5} || o_rd !== 1'b1) begin
         bad++; $display("FAIL rdp_setup: data=%h rd=%b want %h/1", m_data, o_rd, {C_K285_RM, C_D21_5, C_D21_5, C_D21_5});
      end
      drive_one(B2, 1'b0);
      total++;
      if (m_data !== {C_D21_5, C_D21_5, C_D21_5, C_K285_RP} || o_rd !== 1'b0) begin
         bad++; $display("FAIL k285_from_rdp: data=%h rd=%b want %h/0", m_data, o_rd, {C_D21_5, C_D21_5, C_D21_5, C_K285_RP});
      end
      drive_one(B1, 1'b0);
      drive_one(B2, 1'b1);
      total++;
      if (m_data !== {C_D21_5, C_D21_5, C_D21_5, C_K285_RM} || o_rd !== 1'b1) begin
         bad++; $display("FAIL clear_with_accept: data=%h rd=%b want %h/1", m_data, o_rd, {C_D21_5, C_D21_5, C_D21_5, C_K285_RM});
      end
      // clear pulsed alone, then a beat without clear must start from RD-
      rd_clear = 1'b1;
      @(posedge clk); #1;
      rd_clear = 1'b0;
      @(negedge clk);
      drive_one(B2, 1'b0);
      total++;
      if (m_data[9:0] !== C_K285_RM || o_rd !== 1'b1) begin
         bad++; $display("FAIL clear_alone: lane0=%b rd=%b want %b/1", m_data[9:0], o_rd, C_K285_RM);
      end
   endtask

   task automatic test_kerr;
      drive_one({9'h1B5, D21_5, 9'h1F7, 9'h100}, 1'b1);
      total++;
      if (m_valid !== 1'b1 || kerr !== 4'b1001) begin
         bad++; $display("FAIL kerr_flags: valid=%b kerr=%b want 1/1001", m_valid, kerr);
      end
      total++;
      if (m_data !== {C_D21_5, C_D21_5, 10'b1110101000, 10'b1001110100} || o_rd !== 1'b0) begin
         bad++; $display("FAIL kerr_data: data=%h rd=%b want %h/0", m_data, o_rd,
                         {C_D21_5, C_D21_5, 10'b1110101000, 10'b1001110100});
      end
   endtask

   task automatic test_random;
      logic [35:0] q[$];
      logic [35:0] exp;
      logic [39:0] held_data;
      logic [3:0]  held_kerr;
      logic        held_rd, was_stall, acc, rd_ref, ok, k, rdo, exp_kerr, exp_k;
      logic [7:0]  b;
      logic [8:0]  ch;
      int          sent, got;
      m_ready = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      sent = 0; got = 0; was_stall = 1'b0; rd_ref = 1'b0;
      held_data = '0; held_kerr = '0; held_rd = 1'b0;
      for (int cyc = 0; cyc < 400 && got < 40; cyc++) begin
         if (!s_valid && sent < 40 && $urandom_range(0, 3) != 0) begin
            s_valid = 1'b1; s_data = rand_beat();
         end
         rd_clear = s_valid && (sent == 0);
         m_ready  = ($urandom_range(0, 2) != 0);
         @(negedge clk);
         if (was_stall) begin
            total++;
            if (m_valid !== 1'b1 || m_data !== held_data || kerr !== held_kerr || o_rd !== held_rd) begin
               bad++; $display("FAIL stall_hold: valid=%b data=%h kerr=%b rd=%b want 1/%h/%b/%b",
                               m_valid, m_data, kerr, o_rd, held_data, held_kerr, held_rd);
            end
         end
         if (m_valid && m_ready) begin
            was_stall = 1'b0;
            got++;
            total++;
            if (q.size() == 0) begin
               bad++; $display("FAIL dup_beat: output beat %0d with nothing outstanding", got);
            end else begin
               exp = q.pop_front();
               for (int n = 0; n < 4; n++) begin
                  ch = exp[9*n +: 9];
                  exp_kerr = ch[8] && !legal_k_ref(ch[7:0]);
                  exp_k    = ch[8] && !exp_kerr;
                  decode(m_data[10*n +: 10], rd_ref, ok, b, k, rdo);
                  rd_ref = rdo;
                  total++;
                  if (!ok || b !== ch[7:0] || k !== exp_k || kerr[n] !== exp_kerr) begin
                     bad++; $display("FAIL rand_lane%0d: code=%b ok=%b byte=%h k=%b kerr=%b want byte=%h k=%b kerr=%b",
                                     n, m_data[10*n +: 10], ok, b, k, kerr[n], ch[7:0], exp_k, exp_kerr);
                  end
               end
               if (o_rd !== rd_ref) begin
                  bad++; $display("FAIL rand_rd: o_rd=%b want %b", o_rd, rd_ref);
               end
            end
         end else if (m_valid) begin
            was_stall = 1'b1;
            held_data = m_data; held_kerr = kerr; held_rd = o_rd;
            total++;
            if (s_ready !== 1'b0) begin
               bad++; $display("FAIL stall_ready: s_ready=%b want 0", s_ready);
            end
         end else begin
            was_stall = 1'b0;
         end
         acc = s_valid && s_ready;
         if (acc) begin q.push_back(s_data); sent++; end
         @(posedge clk); #1;
         if (acc) s_valid = 1'b0;
      end
      s_valid = 1'b0; rd_clear = 1'b0; m_ready = 1'b1;
      total++;
      if (got != 40 || q.size() != 0) begin
         bad++; $display("FAIL rand_count: got=%0d left=%0d want 40/0", got, q.size());
      end
   endtask

   task automatic test_reset_midstream;
      m_ready = 1'b1;
      @(posedge clk); #1;
      m_ready = 1'b0;
      drive_one(B1, 1'b1);
      @(posedge clk); #1;
      @(negedge clk);
      total++;
      if (m_valid !== 1'b1 || s_ready !== 1'b0 || o_rd !== 1'b1 ||
          m_data !== {C_K285_RM, C_D21_5, C_D21_5, C_D21_5}) begin
         bad++; $display("FAIL stall_before_reset: valid=%b ready=%b rd=%b data=%h want 1/0/1/%h",
                         m_valid, s_ready, o_rd, m_data, {C_K285_RM, C_D21_5, C_D21_5, C_D21_5});
      end
      rst_n = 1'b0;
      #1;
      total++;
      if (m_valid !== 1'b0 || o_rd !== 1'b0 || m_data !== 40'd0) begin
         bad++; $display("FAIL midstream_reset: valid=%b rd=%b data=%h want 0/0/0", m_valid, o_rd, m_data);
      end
      @(posedge clk); #1;
      rst_n = 1'b1; m_ready = 1'b1;
      @(negedge clk);
      drive_one(B2, 1'b0);
      total++;
      if (m_data[9:0] !== C_K285_RM || o_rd !== 1'b1) begin
         bad++; $display("FAIL after_reset_rd: lane0=%b rd=%b want %b/1", m_data[9:0], o_rd, C_K285_RM);
      end
   endtask

   initial begin
      test_reset;
      test_basic;
      test_back_to_back;
      test_rd_clear;
      test_kerr;
      test_random;
      test_reset_midstream;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
